// File: rtl/buyruk_onbellegi_if.sv
// Fetch-side and memory-side bus of the instruction cache.
// slave: the cache itself; master: whoever drives fetch requests and serves refills.
interface buyruk_onbellegi_if;
  logic        getir_istek_i;
  logic [31:0] getir_ps_i;
  logic        getir_gecerli_o;
  logic [31:0] getir_deger_o;
  logic        gecersiz_kil_i;
  logic        anabellek_istek_o;
  logic [31:0] anabellek_adres_o;
  logic        anabellek_gecerli_i;
  logic [31:0] anabellek_veri_i;
  logic [31:0] iska_sayaci_o;

  modport slave (
    input  getir_istek_i, getir_ps_i, gecersiz_kil_i, anabellek_gecerli_i, anabellek_veri_i,
    output getir_gecerli_o, getir_deger_o, anabellek_istek_o, anabellek_adres_o, iska_sayaci_o
  );

  modport master (
    output getir_istek_i, getir_ps_i, gecersiz_kil_i, anabellek_gecerli_i, anabellek_veri_i,
    input  getir_gecerli_o, getir_deger_o, anabellek_istek_o, anabellek_adres_o, iska_sayaci_o
  );
endinterface

// File: rtl/buyruk_onbellegi.sv
// Direct-mapped read-only instruction cache with combinational hit path,
// word-serial line refill, whole-cache invalidate and a miss counter.
module buyruk_onbellegi #(
  parameter int SATIR_SAYISI = 64,
  parameter int SATIR_KELIME = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  buyruk_onbellegi_if.slave   bus
);
  localparam int OFS = $clog2(SATIR_KELIME);
  localparam int IDX = $clog2(SATIR_SAYISI);
  localparam int ETW = 30 - OFS - IDX;
  localparam logic [OFS-1:0] SON_KELIME = OFS'(SATIR_KELIME - 1);

  typedef enum logic {BOSTA = 1'b0, DOLDUR = 1'b1} durum_t;

  durum_t durum_q, durum_d;

  // Storage: data and tags are never reset, only the valid bits are.
  logic [31:0]             veri_q   [SATIR_SAYISI][SATIR_KELIME];
  logic [ETW-1:0]          etiket_q [SATIR_SAYISI];
  logic [SATIR_SAYISI-1:0] gecerli_q;

  logic        istek_q;   // refill beat request
  logic        kirli_q;   // line under refill was hit by an invalidate
  logic [31:0] adres_q;   // current beat word address
  logic [31:0] sayac_q;   // miss counter

  logic [OFS-1:0] kelime, dolgu_kelime;
  logic [IDX-1:0] indeks, dolgu_indeks;
  logic [ETW-1:0] etiket, dolgu_etiket;
  logic           isabet, iska_bas, vurus, son_vurus;
  logic           unused_ps;

  // Lookup fields of the fetch address.
  assign kelime = bus.getir_ps_i[OFS+1:2];
  assign indeks = bus.getir_ps_i[OFS+IDX+1:OFS+2];
  assign etiket = bus.getir_ps_i[31:OFS+IDX+2];
  assign unused_ps = ^bus.getir_ps_i[1:0];

  // The beat address only ever advances within one line, so its upper bits
  // are the latched line base and its word bits are the beat counter.
  assign dolgu_kelime = adres_q[OFS+1:2];
  assign dolgu_indeks = adres_q[OFS+IDX+1:OFS+2];
  assign dolgu_etiket = adres_q[31:OFS+IDX+2];

  assign isabet = gecerli_q[indeks] && (etiket_q[indeks] == etiket);

  assign bus.anabellek_istek_o = istek_q;
  assign bus.anabellek_adres_o = adres_q;
  assign bus.iska_sayaci_o     = sayac_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) durum_q <= BOSTA;
    else       durum_q <= durum_d;
  end

  // Next state: leave idle on a miss, return once the last beat lands.
  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOSTA:   if (iska_bas)  durum_d = DOLDUR;
      DOLDUR:  if (son_vurus) durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  // Outputs and strobes: hit response only while idle; beats only while refilling.
  always_comb begin
    bus.getir_gecerli_o = bus.getir_istek_i && isabet && (durum_q == BOSTA);
    bus.getir_deger_o   = veri_q[indeks][kelime];
    iska_bas  = (durum_q == BOSTA) && bus.getir_istek_i && !isabet && !bus.gecersiz_kil_i;
    vurus     = (durum_q == DOLDUR) && bus.anabellek_gecerli_i;
    son_vurus = vurus && (dolgu_kelime == SON_KELIME);
  end

  // Refill control: request flag, beat address, dirty flag and miss counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      istek_q <= 1'b0;
      kirli_q <= 1'b0;
      adres_q <= '0;
      sayac_q <= '0;
    end else begin
      if (iska_bas) begin
        istek_q <= 1'b1;
        kirli_q <= 1'b0;
        adres_q <= {bus.getir_ps_i[31:OFS+2], {(OFS+2){1'b0}}};
        sayac_q <= sayac_q + 32'd1;
      end
      if ((durum_q == DOLDUR) && bus.gecersiz_kil_i) kirli_q <= 1'b1;
      if (vurus) begin
        if (son_vurus) istek_q <= 1'b0;
        else           adres_q <= adres_q + 32'd4;
      end
    end
  end

  // Valid bits: invalidate wins over the line completing in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.gecersiz_kil_i) gecerli_q <= '0;
    else if (son_vurus && !kirli_q)  gecerli_q[dolgu_indeks] <= 1'b1;
  end

  // Data and tag arrays, written by refill beats.
  always_ff @(posedge clk_i) begin
    if (!rst_i && vurus) veri_q[dolgu_indeks][dolgu_kelime] <= bus.anabellek_veri_i;
    if (!rst_i && son_vurus) etiket_q[dolgu_indeks] <= dolgu_etiket;
  end
endmodule

// File: tb/tb_buyruk_onbellegi.sv
// Bench for buyruk_onbellegi: directed scenarios followed by random fetches,
// checked against a line-level model of the cache and a fixed memory image.
module tb_buyruk_onbellegi;
  localparam int SS  = 64;
  localparam int SK  = 4;
  localparam int OFS = $clog2(SK);
  localparam int IDX = $clog2(SS);

  logic        clk = 1'b0;
  logic        rst;
  logic        istek, inval, stall_en;
  logic [31:0] ps;
  logic [1:0]  stall_cnt;

  int errs = 0;
  int checks = 0;

  // Model state: per-line valid/tag and the expected miss count.
  bit          mv [SS];
  logic [31:0] mt [SS];
  int unsigned misses;

  always #5 clk = ~clk;

  buyruk_onbellegi_if bus();

  buyruk_onbellegi #(.SATIR_SAYISI(SS), .SATIR_KELIME(SK)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Memory image: line 0x100 holds 0xA0..0xA3, everything else is a hash of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    logic [31:0] w;
    w = (a / 4) * 4;
    if (w / 16 == 32'h10) return 32'hA0 + (w - 32'h100) / 4;
    return (w * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign bus.getir_istek_i       = istek;
  assign bus.getir_ps_i          = ps;
  assign bus.gecersiz_kil_i      = inval;
  assign bus.anabellek_gecerli_i = bus.anabellek_istek_o && (!stall_en || stall_cnt == 2'd0);
  assign bus.anabellek_veri_i    = mem_fn(bus.anabellek_adres_o);

  always @(posedge clk) begin
    if (rst) stall_cnt <= 2'd0;
    else     stall_cnt <= (stall_cnt == 2'd2) ? 2'd0 : stall_cnt + 2'd1;
  end

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / (SK * 4)) % SS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (SK * 4 * SS);
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return (a / (SK * 4)) * (SK * 4);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return mv[idx_of(a)] && (mt[idx_of(a)] == tag_of(a));
  endfunction

  function automatic void m_clear();
    foreach (mv[i]) mv[i] = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One fetch of address a. On a miss the refill is followed beat by beat;
  // optionally the PC is redirected two cycles into the refill, and/or an
  // invalidate is pulsed during beat inval_beat.
  task automatic fetch(input logic [31:0] a, input logic [31:0] redir, input int inval_beat);
    int n, beat;
    bit seen, dirty, done, pulsed;
    logic [31:0] base;
    ps = a;
    istek = 1'b1;
    @(negedge clk);
    if (m_hit(a)) begin
      chk("hit_vld",   32'(bus.getir_gecerli_o), 32'd1);
      chk("hit_data",  bus.getir_deger_o, mem_fn(a));
      chk("hit_nomem", 32'(bus.anabellek_istek_o), 32'd0);
      chk("hit_cnt",   bus.iska_sayaci_o, misses);
    end else begin
      chk("miss_vld", 32'(bus.getir_gecerli_o), 32'd0);
      misses++;
      base = base_of(a);
      n = 0; beat = 0; seen = 0; dirty = 0; done = 0; pulsed = 0;
      while (!done && n < 200) begin
        @(negedge clk);
        n++;
        inval = 1'b0;
        if (bus.anabellek_istek_o) begin
          seen = 1;
          chk("fill_addr", bus.anabellek_adres_o, base + 32'(4 * beat));
          chk("fill_vld0", 32'(bus.getir_gecerli_o), 32'd0);
          if (inval_beat == beat && !pulsed) begin
            inval = 1'b1; pulsed = 1; dirty = 1; m_clear();
          end
          if (redir != 32'd0 && n == 2) ps = redir;
          if (bus.anabellek_gecerli_i) beat++;
        end else if (seen) begin
          done = 1;
        end
      end
      inval = 1'b0;
      chk("fill_done",  32'(done), 32'd1);
      chk("fill_beats", 32'(beat), 32'(SK));
      if (!stall_en && inval_beat < 0) chk("fill_lat", 32'(n), 32'(SK + 1));
      if (!dirty) begin
        mv[idx_of(a)] = 1'b1;
        mt[idx_of(a)] = tag_of(a);
      end
      chk("fill_cnt", bus.iska_sayaci_o, misses);
      if (m_hit(ps)) begin
        chk("after_vld",  32'(bus.getir_gecerli_o), 32'd1);
        chk("after_data", bus.getir_deger_o, mem_fn(ps));
      end else begin
        chk("after_vld", 32'(bus.getir_gecerli_o), 32'd0);
        istek = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  // Invalidate while idle, with a request present that must not start a miss.
  task automatic inval_bosta(input logic [31:0] a);
    ps = a;
    istek = 1'b1;
    inval = 1'b1;
    @(negedge clk);
    chk("inv_vld", 32'(bus.getir_gecerli_o), 32'(m_hit(a)));
    if (m_hit(a)) chk("inv_data", bus.getir_deger_o, mem_fn(a));
    @(posedge clk); #1;
    inval = 1'b0;
    istek = 1'b0;
    m_clear();
    @(negedge clk);
    chk("inv_nomiss", 32'(bus.anabellek_istek_o), 32'd0);
    chk("inv_cnt",    bus.iska_sayaci_o, misses);
    @(posedge clk); #1;
  endtask

  initial begin
    int pick_idx [4];
    logic [31:0] a;
    int r;
    pick_idx = '{0, 1, 16, 63};
    rst = 1'b1; istek = 1'b1; ps = 32'h100; inval = 1'b0; stall_en = 1'b0;
    m_clear();
    misses = 0;

    // Reset state, with a request pending.
    @(negedge clk);
    chk("rst_vld", 32'(bus.getir_gecerli_o), 32'd0);
    chk("rst_req", 32'(bus.anabellek_istek_o), 32'd0);
    chk("rst_adr", bus.anabellek_adres_o, 32'd0);
    chk("rst_cnt", bus.iska_sayaci_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    istek = 1'b0;

    // Cold miss then hit stream.
    fetch(32'h104, 32'd0, -1);
    chk("cold_cnt", bus.iska_sayaci_o, 32'd1);
    fetch(32'h100, 32'd0, -1);
    fetch(32'h108, 32'd0, -1);
    fetch(32'h10C, 32'd0, -1);
    chk("stream_cnt", bus.iska_sayaci_o, 32'd1);

    // Conflict eviction.
    fetch(32'h500, 32'd0, -1);
    fetch(32'h100, 32'd0, -1);
    chk("evict_cnt", bus.iska_sayaci_o, 32'd3);

    // Memory stalls, with a redirect to a valid line mid-refill.
    stall_en = 1'b1;
    fetch(32'h2040, 32'h108, -1);
    stall_en = 1'b0;

    // Invalidate while idle, then invalidate during beat 2 of a refill.
    inval_bosta(32'h100);
    fetch(32'h100, 32'd0, -1);
    fetch(32'h3080, 32'd0, 2);
    fetch(32'h3080, 32'd0, -1);

    // Reset in the middle of a refill.
    ps = 32'h4000;
    istek = 1'b1;
    @(negedge clk);
    chk("mr_miss", 32'(bus.getir_gecerli_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mr_beat2", bus.anabellek_adres_o, 32'h4008);
    rst = 1'b1;
    istek = 1'b0;
    @(negedge clk);
    chk("mr_req", 32'(bus.anabellek_istek_o), 32'd0);
    chk("mr_cnt", bus.iska_sayaci_o, 32'd0);
    chk("mr_adr", bus.anabellek_adres_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_clear();
    misses = 0;
    fetch(32'h4000, 32'd0, -1);

    // Random traffic over a few conflicting lines.
    for (int k = 0; k < 150; k++) begin
      stall_en = ($urandom_range(0, 3) == 0);
      a = (32'($urandom_range(0, 3)) << (OFS + IDX + 2))
        | (32'(pick_idx[$urandom_range(0, 3)]) << (OFS + 2))
        | (32'($urandom_range(0, SK - 1)) << 2);
      r = int'($urandom_range(0, 9));
      if (r == 0)      inval_bosta(a);
      else if (r == 1) fetch(a, 32'd0, int'($urandom_range(0, SK - 1)));
      else             fetch(a, 32'd0, -1);
    end
    stall_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
